// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer and occupancy controller for the register-file FIFO.
// Qualifies raw write/read requests into strobes, keeps the write/read
// pointers (wrapping at depth-1, any depth >= 2) and the count/full/empty
// status. Optional sticky overflow/underflow flags are built only when the
// FIFO_CTRL_ERR_EN macro is defined; the default build omits them.
module fifo_ctrl #(
  parameter int bits  = 8,   // unused here; keeps the sibling parameter list
  parameter int depth = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic                       rd_en,
  output logic [$clog2(depth)-1:0]   wr_ptr,
  output logic [$clog2(depth)-1:0]   rd_ptr,
  output logic                       wr_strobe,
  output logic                       rd_strobe,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(depth+1)-1:0] count
`ifdef FIFO_CTRL_ERR_EN
  ,
  output logic                       ovf,
  output logic                       udf
`endif
);

  localparam int PW = $clog2(depth);
  localparam int CW = $clog2(depth + 1);

  localparam logic [PW-1:0] PTR_LAST  = PW'(depth - 1);
  localparam logic [CW-1:0] CNT_DEPTH = CW'(depth);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          full_q,   full_d;
  logic          empty_q,  empty_d;

  // A read is legal whenever something is stored; a write is legal when there
  // is room or when a read frees the slot in the same cycle. No fall-through:
  // the read side only looks at registered occupancy.
  assign rd_strobe = rd_en & ~empty_q;
  assign wr_strobe = wr_en & (~full_q | rd_strobe);

  // Next-state for pointers and occupancy.
  always_comb begin
    // NOTE: every variable gets a default before any branch so the block stays
    // purely combinational; a path that skips an assignment infers a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    // Explicit wrap compare instead of natural overflow so non-power-of-two
    // depths never reach an index >= depth.
    if (wr_strobe) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
    end
    if (rd_strobe) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
    end

    unique case ({wr_strobe, rd_strobe})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Flags are derived from the next count so they move on the same edge.
    full_d  = (count_d == CNT_DEPTH);
    empty_d = (count_d == '0);
  end

  // State register; reset has priority over any request in the same cycle.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values from
    // before this edge, independent of statement order.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign wr_ptr = wr_ptr_q;
  assign rd_ptr = rd_ptr_q;
  assign count  = count_q;
  assign full   = full_q;
  assign empty  = empty_q;

`ifdef FIFO_CTRL_ERR_EN
  logic ovf_q, udf_q;

  // Sticky error flags: a write into a full FIFO with no read to make room,
  // or any read request while empty. Cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | (wr_en & full_q & ~rd_en);
      udf_q <= udf_q | (rd_en & empty_q);
    end
  end

  assign ovf = ovf_q;
  assign udf = udf_q;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: self-checking bench for fifo_ctrl (depth=10). A short vector
// table, directed corner sequences and a randomized run, all compared against
// a model that tracks total accepted writes/reads since reset.
module tb_fifo_ctrl;

  localparam int DEPTH = 10;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst, wr_en, rd_en;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          wr_strobe, rd_strobe, full, empty;
  logic [CW-1:0] count;
  logic          ovf, udf;

  int checks   = 0;
  int failures = 0;

  // Reference model: totals of accepted writes/reads since the last reset.
  int  m_nw, m_nr;
  bit  m_ovf, m_udf;

  fifo_ctrl #(.bits(8), .depth(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .wr_ptr    (wr_ptr),
    .rd_ptr    (rd_ptr),
    .wr_strobe (wr_strobe),
    .rd_strobe (rd_strobe),
    .full      (full),
    .empty     (empty),
    .count     (count)
`ifdef FIFO_CTRL_ERR_EN
    ,
    .ovf       (ovf),
    .udf       (udf)
`endif
  );

`ifndef FIFO_CTRL_ERR_EN
  assign ovf = 1'b0;
  assign udf = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic rst, wr, rd;
    logic ws, rs;          // expected strobes before the edge
    int   wp, rp, cnt;     // expected state after the edge
    logic fl, em, ov, ud;
  } vec_t;

  vec_t vecs[9];

  task automatic hard_reset();
    @(negedge clk);
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_nw = 0; m_nr = 0; m_ovf = 1'b0; m_udf = 1'b0;
  endtask

  // One cycle against the model: strobes checked before the edge, state after.
  task automatic apply(input logic r, input logic w, input logic d);
    int  cnt;
    bit  ers, ews;
    cnt = m_nw - m_nr;
    ers = d && (cnt > 0);
    ews = w && ((cnt < DEPTH) || ers);
    @(negedge clk);
    rst = r; wr_en = w; rd_en = d;
    #1;
    check("wr_strobe", wr_strobe, ews);
    check("rd_strobe", rd_strobe, ers);
    if (r) begin
      m_nw = 0; m_nr = 0; m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      if (w && cnt == DEPTH && !d) m_ovf = 1'b1;
      if (d && cnt == 0)           m_udf = 1'b1;
      m_nw += int'(ews);
      m_nr += int'(ers);
    end
    @(posedge clk); #1;
    cnt = m_nw - m_nr;
    check("wr_ptr", wr_ptr, m_nw % DEPTH);
    check("rd_ptr", rd_ptr, m_nr % DEPTH);
    check("count",  count,  cnt);
    check("full",   full,   cnt == DEPTH);
    check("empty",  empty,  cnt == 0);
`ifdef FIFO_CTRL_ERR_EN
    check("ovf", ovf, m_ovf);
    check("udf", udf, m_udf);
`endif
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;

    //          rst  wr   rd   ws   rs   wp rp cnt fl   em   ov   ud
    vecs[0] = '{1'b0,1'b0,1'b1,1'b0,1'b0, 0, 0, 0, 1'b0,1'b1,1'b0,1'b1};
    vecs[1] = '{1'b0,1'b1,1'b1,1'b1,1'b0, 1, 0, 1, 1'b0,1'b0,1'b0,1'b1};
    vecs[2] = '{1'b0,1'b1,1'b1,1'b1,1'b1, 2, 1, 1, 1'b0,1'b0,1'b0,1'b1};
    vecs[3] = '{1'b0,1'b1,1'b0,1'b1,1'b0, 3, 1, 2, 1'b0,1'b0,1'b0,1'b1};
    vecs[4] = '{1'b0,1'b0,1'b1,1'b0,1'b1, 3, 2, 1, 1'b0,1'b0,1'b0,1'b1};
    vecs[5] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 3, 2, 1, 1'b0,1'b0,1'b0,1'b1};
    vecs[6] = '{1'b0,1'b0,1'b1,1'b0,1'b1, 3, 3, 0, 1'b0,1'b1,1'b0,1'b1};
    vecs[7] = '{1'b1,1'b1,1'b0,1'b1,1'b0, 0, 0, 0, 1'b0,1'b1,1'b0,1'b0};
    vecs[8] = '{1'b0,1'b1,1'b0,1'b1,1'b0, 1, 0, 1, 1'b0,1'b0,1'b0,1'b0};

    hard_reset();
    check("reset_wr_ptr", wr_ptr, 0);
    check("reset_rd_ptr", rd_ptr, 0);
    check("reset_count",  count,  0);
    check("reset_full",   full,   0);
    check("reset_empty",  empty,  1);
    check("reset_ws",     wr_strobe, 0);
    check("reset_rs",     rd_strobe, 0);

    // Vector table.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      rst = vecs[i].rst; wr_en = vecs[i].wr; rd_en = vecs[i].rd;
      #1;
      check($sformatf("vec%0d_ws", i), wr_strobe, vecs[i].ws);
      check($sformatf("vec%0d_rs", i), rd_strobe, vecs[i].rs);
      @(posedge clk); #1;
      check($sformatf("vec%0d_wp", i),    wr_ptr, vecs[i].wp);
      check($sformatf("vec%0d_rp", i),    rd_ptr, vecs[i].rp);
      check($sformatf("vec%0d_cnt", i),   count,  vecs[i].cnt);
      check($sformatf("vec%0d_full", i),  full,   vecs[i].fl);
      check($sformatf("vec%0d_empty", i), empty,  vecs[i].em);
`ifdef FIFO_CTRL_ERR_EN
      check($sformatf("vec%0d_ovf", i), ovf, vecs[i].ov);
      check($sformatf("vec%0d_udf", i), udf, vecs[i].ud);
`endif
    end

    // Fill to full: write pointer wraps 9 -> 0.
    hard_reset();
    for (int i = 0; i < DEPTH; i++) apply(1'b0, 1'b1, 1'b0);
    check("fill_full",   full,   1);
    check("fill_count",  count,  DEPTH);
    check("fill_wp_wrap", wr_ptr, 0);
    check("fill_rp",     rd_ptr, 0);

    // Write while full with no read is dropped.
    apply(1'b0, 1'b1, 1'b0);
    check("ovf_drop_count", count, DEPTH);

    // Full with simultaneous read and write, 25 cycles in lockstep.
    for (int i = 0; i < 25; i++) apply(1'b0, 1'b1, 1'b1);
    check("lockstep_count", count, DEPTH);
    check("lockstep_wp", wr_ptr, 5);
    check("lockstep_rp", rd_ptr, 5);

    // Drain, then one read too many.
    for (int i = 0; i < DEPTH; i++) apply(1'b0, 1'b0, 1'b1);
    check("drain_empty", empty, 1);
    apply(1'b0, 1'b0, 1'b1);
    check("udf_drop_count", count, 0);

    // Reset in the middle of operation at count=6 with a write pending.
    hard_reset();
    for (int i = 0; i < 6; i++) apply(1'b0, 1'b1, 1'b0);
    check("pre_rst_count", count, 6);
    apply(1'b1, 1'b1, 1'b0);
    check("mid_rst_count", count, 0);
    check("mid_rst_wp", wr_ptr, 0);
    apply(1'b0, 1'b1, 1'b0);
    check("post_rst_wp", wr_ptr, 1);

    // Randomized traffic with occasional reset; bias shifts so both full and
    // empty regions are visited often.
    for (int i = 0; i < 3000; i++) begin
      int bias;
      bias = ((i / 200) % 2 == 0) ? 70 : 30;
      apply($urandom_range(0, 99) == 0,
            $urandom_range(0, 99) < bias,
            $urandom_range(0, 99) < (100 - bias));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Pointer and occupancy controller for the register-file FIFO. It turns raw write/read requests into qualified strobes, and it drives the write pointer that selects the target register through the FIFO's demultiplexer stage. It also provides the read pointer for the output multiplexer and full/empty/count status. All state is registered on one clock. The depth need not be a power of two.

## Interface
- `bits`, 8, data word width. Not used internally; kept for a parameter list matching the sibling stages.
- `depth`, 10, number of FIFO entries; must be ≥ 2.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous, active-high reset.
- `wr_en`  input  1  write request.
- `rd_en`  input  1  read request.
- `wr_ptr`  output  $clog2(depth)  index of the next slot to write; drives the demux `ctrl`.
- `rd_ptr`  output  $clog2(depth)  index of the oldest valid slot; drives the output mux select.
- `wr_strobe`  output  1  qualified write; this cycle's data is stored at `wr_ptr`.
- `rd_strobe`  output  1  qualified read; the data at `rd_ptr` is consumed this cycle.
- `full`  output  1  count == depth.
- `empty`  output  1  count == 0.
- `count`  output  $clog2(depth+1)  number of valid entries.
- `ovf`  output  1  sticky overflow flag; present only with FIFO_CTRL_ERR_EN.
- `udf`  output  1  sticky underflow flag; present only with FIFO_CTRL_ERR_EN.

## Operation
- Write qualification: `wr_strobe = wr_en & (~full | rd_strobe)`. This is combinational from the registered state and the inputs.
- Read qualification: `rd_strobe = rd_en & ~empty`. There is no fall-through: a write to an empty FIFO is not readable in the same cycle.
- Pointer update:
  - On `wr_strobe`, `wr_ptr` advances.
  - On `rd_strobe`, `rd_ptr` advances.
  - Each pointer wraps from depth-1 to 0. It never takes a value ≥ depth, including for non-power-of-two depths.
- Count update:
  - +1 on write only.
  - −1 on read only.
  - Unchanged on both or neither.
- `full` and `empty` are registered and updated together with `count`. They are never both 1.
- Simultaneous events:
  - Empty with wr_en and rd_en: write accepted, read rejected, count goes to 1.
  - Full with wr_en and rd_en: both accepted, count stays at depth, both pointers advance. The slot being read is the slot being overwritten; the read sees the old data because storage updates on the clock edge.
  - Full with wr_en only: write dropped, nothing changes.
  - Empty with rd_en only: read dropped, nothing changes.
- Reset values: `wr_ptr`=0, `rd_ptr`=0, `count`=0, `empty`=1, `full`=0, `wr_strobe`/`rd_strobe` follow the inputs (0 when idle), `ovf`=0, `udf`=0.
- A reset asserted mid-operation discards all entries. Stored data is not cleared; it is treated as invalid.

## Timing
- Strobes are combinational, with zero latency from `wr_en`/`rd_en`.
- Pointers, count, full, empty and flags change on the rising edge after a qualified strobe.
- Write-to-read latency is 1 cycle: data written at edge N can be read in cycle N+1.
- Reset takes effect at the first rising edge with `rst`=1. It has priority over all requests in that cycle.
- Back-to-back writes and reads are sustained at 1 per cycle. There are no bubbles, including at pointer wrap.

## Configuration
- FIFO_CTRL_ERR_EN defined:
  - `ovf` sets on any cycle with `wr_en & full & ~rd_en`.
  - `udf` sets on any cycle with `rd_en & empty`.
  - Both flags hold until `rst`.
- FIFO_CTRL_ERR_EN undefined: the `ovf`/`udf` ports and their logic are absent. Dropped requests are silent.

## Test plan
- Reset, then 10 writes with depth=10 -> `wr_ptr` runs 1..9 then 0, `full`=1 after the 10th edge, `count`=10, `rd_ptr`=0.
- 11th write while full, with no read -> `wr_strobe`=0, state unchanged; `ovf`=1 if FIFO_CTRL_ERR_EN.
- Full, then 10 reads -> `rd_ptr` wraps 9->0, `empty`=1, `count`=0; an 11th read gives `rd_strobe`=0 and `udf`=1 if enabled.
- From empty, wr_en=rd_en=1 for 1 cycle -> `wr_strobe`=1, `rd_strobe`=0, `count`=1; next cycle both asserted -> `count` stays 1 and both pointers advance.
- Full, wr_en=rd_en=1 for 25 cycles -> `count` holds 10, pointers stay 0..9 and advance in lockstep, no flag set.
- `rst` asserted at `count`=6 with wr_en=1 -> after the edge, all outputs at reset values; the next write lands at `wr_ptr`=0.
